// File: rtl/bcd_counter_ndigit_pkg.sv
// Shared BCD digit type, digit limits and per-digit arithmetic helpers.
// Every helper returns {flag, digit}:
//   bcd_inc   - flag = carry out (the digit was 9 and rolled to 0)
//   bcd_dec   - flag = borrow out (the digit was 0 and rolled to 9)
//   bcd_clamp - flag = the input nibble was out of range and was clamped
package bcd_cnt_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX = 4'd9;
    localparam bcd_t BCD_MIN = 4'd0;

    function automatic logic [4:0] bcd_clamp(input bcd_t d);
        if (d > BCD_MAX) begin
            return {1'b1, BCD_MAX};
        end
        return {1'b0, d};
    endfunction

    function automatic logic [4:0] bcd_inc(input bcd_t d);
        if (d >= BCD_MAX) begin
            return {1'b1, BCD_MIN};
        end
        return {1'b0, d + 4'd1};
    endfunction

    function automatic logic [4:0] bcd_dec(input bcd_t d);
        if (d == BCD_MIN) begin
            return {1'b1, BCD_MAX};
        end
        return {1'b0, d - 4'd1};
    endfunction

endpackage

// File: rtl/bcd_counter_ndigit_if.sv
// Control and display bus of the N-digit BCD counter.
// The master side drives the controls and reads the count; the counter
// itself attaches through the slave modport.
// Optional macro: BCD_CNT_DOWN_EN adds the i_Down direction control.
interface bcd_counter_ndigit_if #(
    parameter int DIGITS = 2
);
    logic                  i_Enable;
    logic                  i_Clear;
    logic                  i_Load;
    logic [4*DIGITS-1:0]   i_Load_Value;
`ifdef BCD_CNT_DOWN_EN
    logic                  i_Down;
`endif
    logic [4*DIGITS-1:0]   o_Digits;
    logic                  o_Tick;
    logic                  o_Wrap;
    logic                  o_Zero;

`ifdef BCD_CNT_DOWN_EN
    modport master (
        output i_Enable, i_Clear, i_Load, i_Load_Value, i_Down,
        input  o_Digits, o_Tick, o_Wrap, o_Zero
    );
    modport slave (
        input  i_Enable, i_Clear, i_Load, i_Load_Value, i_Down,
        output o_Digits, o_Tick, o_Wrap, o_Zero
    );
`else
    modport master (
        output i_Enable, i_Clear, i_Load, i_Load_Value,
        input  o_Digits, o_Tick, o_Wrap, o_Zero
    );
    modport slave (
        input  i_Enable, i_Clear, i_Load, i_Load_Value,
        output o_Digits, o_Tick, o_Wrap, o_Zero
    );
`endif

endinterface

// File: rtl/bcd_counter_ndigit_tick_gen.sv
// Clock-enable prescaler: emits a registered one-cycle tick every
// CLK_HZ/TICK_HZ enabled cycles. Pausing holds the phase so a resumed
// interval continues where it stopped; clear restarts the interval.
module tick_gen #(
    parameter int CLK_HZ  = 25000000,
    parameter int TICK_HZ = 1
) (
    input  logic i_Clk,
    input  logic i_Rst_n,
    input  logic i_Enable,
    input  logic i_Clear,
    output logic o_Tick
);
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV >= 2) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(DIV - 1);

    if (DIV < 2) begin : g_bad_div
        $error("tick_gen: CLK_HZ/TICK_HZ must be at least 2");
    end

    logic [PW-1:0] p_q;
    logic [PW-1:0] p_d;
    logic          tick_q;
    logic          tick_d;

    // Next phase and tick: clear restarts, pause holds the phase and drops the tick.
    always_comb begin
        p_d    = p_q;
        tick_d = 1'b0;
        if (i_Clear) begin
            p_d = '0;
        end else if (i_Enable) begin
            if (p_q == P_LAST) begin
                p_d    = '0;
                tick_d = 1'b1;
            end else begin
                p_d = p_q + PW'(1);
            end
        end
    end

    // Prescaler phase and tick registers.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            p_q    <= '0;
            tick_q <= 1'b0;
        end else begin
            p_q    <= p_d;
            tick_q <= tick_d;
        end
    end

    assign o_Tick = tick_q;

endmodule

// File: rtl/bcd_counter_ndigit.sv
// N-digit BCD counter with built-in tick prescaler, pause, synchronous
// clear, clamped parallel load and wrap/saturate at the limits.
// Optional macro: BCD_CNT_DOWN_EN adds down-counting via bus.i_Down.
// Each digit works out its own stepped value and limit flag; the carry
// (or borrow) into a digit is the AND of the limit flags below it, so the
// chain is a lookahead rather than a ripple through the stepped values.
module bcd_counter_ndigit
    import bcd_cnt_pkg::*;
#(
    parameter int CLK_HZ   = 25000000,
    parameter int TICK_HZ  = 1,
    parameter int DIGITS   = 2,
    parameter int SATURATE = 0
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst_n,
    bcd_counter_ndigit_if.slave  bus
);
    if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
        $error("bcd_counter_ndigit: DIGITS must be in 1..8");
    end

    logic                    tick;
    logic                    count_en;
    logic                    limit;
    logic [DIGITS-1:0]       at_lim;
    logic [DIGITS-1:0]       carry_in;
    bcd_t [DIGITS-1:0]       step_digit;
    bcd_t [DIGITS-1:0]       load_digit;
    bcd_t [DIGITS-1:0]       digits_q;
    bcd_t [DIGITS-1:0]       digits_d;
    logic                    wrap_q;
    logic                    wrap_d;

    tick_gen #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ)
    ) u_tick_gen (
        .i_Clk    (i_Clk),
        .i_Rst_n  (i_Rst_n),
        .i_Enable (bus.i_Enable),
        .i_Clear  (bus.i_Clear),
        .o_Tick   (tick)
    );

    // A tick only counts if the counter is still enabled when it is seen.
    assign count_en = tick & bus.i_Enable;

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        logic [4:0] inc_r;
        logic [4:0] step_r;
        logic [4:0] clamp_r;
`ifdef BCD_CNT_DOWN_EN
        logic [4:0] dec_r;

        assign dec_r  = bcd_dec(digits_q[gi]);
        assign inc_r  = bcd_inc(digits_q[gi]);
        assign step_r = bus.i_Down ? dec_r : inc_r;
`else
        assign inc_r  = bcd_inc(digits_q[gi]);
        assign step_r = inc_r;
`endif
        assign at_lim[gi] = step_r[4];

        if (gi == 0) begin : g_lsd
            assign carry_in[gi] = count_en;
        end else begin : g_upper
            assign carry_in[gi] = count_en & (&at_lim[gi-1:0]);
        end

        assign step_digit[gi] = carry_in[gi] ? step_r[3:0] : digits_q[gi];

        assign clamp_r        = bcd_clamp(bus.i_Load_Value[4*gi +: 4]);
        assign load_digit[gi] = clamp_r[4] ? BCD_MAX : clamp_r[3:0];
    end

    // Every digit at its limit while counting means the whole count overflows.
    assign limit = count_en & (&at_lim);

    // Next count: clear beats load beats count; a load swallows a coincident tick.
    always_comb begin
        digits_d = digits_q;
        wrap_d   = 1'b0;
        if (bus.i_Clear) begin
            digits_d = '0;
        end else if (bus.i_Load) begin
            digits_d = load_digit;
        end else if (limit) begin
            wrap_d = 1'b1;
            if (SATURATE == 0) begin
                digits_d = step_digit;
            end
        end else begin
            digits_d = step_digit;
        end
    end

    // Digit and limit-pulse registers.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            digits_q <= '0;
            wrap_q   <= 1'b0;
        end else begin
            digits_q <= digits_d;
            wrap_q   <= wrap_d;
        end
    end

    assign bus.o_Digits = digits_q;
    assign bus.o_Tick   = tick;
    // Masked by clear so a limit pulse never overlaps a clear request.
    assign bus.o_Wrap   = wrap_q & ~bus.i_Clear;
    assign bus.o_Zero   = (digits_q == '0);

endmodule
